// File: rtl/nn_fp16_pkg.sv
// ---------------------------------------------------------------------------
// nn_fp16_pkg
// Shared fp16 types and constants for the neural-network datapath, plus the
// state encoding of the neuron sequencer.
// ---------------------------------------------------------------------------
package nn_fp16_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_POS_ZERO = 16'h0000;
    localparam int    FP16_SIGN_BIT = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } nseq_state_t;

    // Sign test only: -0 and negative NaNs count as negative.
    function automatic logic fp16_is_neg(input fp16_t v);
        return v[FP16_SIGN_BIT];
    endfunction

endpackage

// File: rtl/neuron_seq_fp16_if.sv
// ---------------------------------------------------------------------------
// neuron_seq_fp16_if
// Bundles everything the neuron sequencer exchanges with its surroundings:
//   control   : start, w_base, busy
//   memories  : rd_en, x_addr, w_addr, x_data, w_data
//   MAC       : mac_clr, mac_en, mac_x, mac_c, mac_o
//   result    : o, o_valid, o_ready
// modport master : the sequencer itself
// modport slave  : memories, MAC, controller and downstream layer
// ---------------------------------------------------------------------------
interface neuron_seq_fp16_if #(
    parameter int AW  = 10,
    parameter int WAW = 17
) ();
    import nn_fp16_pkg::*;

    logic           start;
    logic [WAW-1:0] w_base;
    logic           busy;

    logic           rd_en;
    logic [AW-1:0]  x_addr;
    logic [WAW-1:0] w_addr;
    fp16_t          x_data;
    fp16_t          w_data;

    logic           mac_clr;
    logic           mac_en;
    fp16_t          mac_x;
    fp16_t          mac_c;
    fp16_t          mac_o;

    fp16_t          o;
    logic           o_valid;
    logic           o_ready;

    modport master (
        input  start, w_base, x_data, w_data, mac_o, o_ready,
        output busy, rd_en, x_addr, w_addr, mac_clr, mac_en, mac_x, mac_c,
               o, o_valid
    );

    modport slave (
        output start, w_base, x_data, w_data, mac_o, o_ready,
        input  busy, rd_en, x_addr, w_addr, mac_clr, mac_en, mac_x, mac_c,
               o, o_valid
    );

endinterface

// File: rtl/neuron_seq_fp16_chk.sv
// ---------------------------------------------------------------------------
// neuron_seq_fp16_chk
// Protocol checker for the neuron sequencer, observing only its ports:
//   - mac_clr and mac_en never overlap
//   - rd_en never high while idle (busy = 0) or holding a result (o_valid)
//   - exactly N_IN mac_en cycles between the clear and the result
// Inputs: clk, rst_n, busy, rd_en, mac_clr, mac_en, o_valid.
// ---------------------------------------------------------------------------
module neuron_seq_fp16_chk #(
    parameter int N_IN = 784
) (
    input logic clk,
    input logic rst_n,
    input logic busy,
    input logic rd_en,
    input logic mac_clr,
    input logic mac_en,
    input logic o_valid
);

    localparam int CW = $clog2(N_IN + 2);

    logic [CW-1:0] en_cnt_q;
    logic [CW-1:0] en_cnt_d;
    logic          o_valid_prev_q;

    // Count accumulate cycles since the last clear.
    always_comb begin
        en_cnt_d = en_cnt_q;
        if (mac_clr) begin
            en_cnt_d = {CW{1'b0}};
        end else if (mac_en) begin
            en_cnt_d = en_cnt_q + CW'(1);
        end else begin
            en_cnt_d = en_cnt_q;
        end
    end

    // Counter and o_valid history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt_q       <= {CW{1'b0}};
            o_valid_prev_q <= 1'b0;
        end else begin
            en_cnt_q       <= en_cnt_d;
            o_valid_prev_q <= o_valid;
        end
    end

    a_clr_en_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(mac_clr && mac_en));

    a_rd_idle_done : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && (!busy || o_valid)));

    a_en_count : assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !o_valid_prev_q) |-> (en_cnt_q == CW'(N_IN)));

endmodule

// File: rtl/relu_fp16.sv
// ---------------------------------------------------------------------------
// relu_fp16
// Combinational fp16 ReLU. Any value with the sign bit set (including -0
// and negative NaNs) becomes +0 when en = 1; everything else, including
// positive NaN payloads, passes unchanged.
//   a  : fp16 input
//   en : 1 = clamp, 0 = bypass
//   y  : fp16 output
// ---------------------------------------------------------------------------
module relu_fp16
    import nn_fp16_pkg::*;
(
    input  fp16_t a,
    input  logic  en,
    output fp16_t y
);

    // Clamp on sign bit only; no NaN decoding is needed.
    always_comb begin
        y = a;
        if (en && fp16_is_neg(a)) begin
            y = FP16_POS_ZERO;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/neuron_seq_fp16.sv
// ---------------------------------------------------------------------------
// neuron_seq_fp16
// Control stage for one fp16 MAC neuron lane. On start it clears the MAC,
// streams N_IN (input, weight) pairs from two 1-cycle-latency memories into
// the MAC, captures the sum (optionally ReLU-clamped) and offers it on a
// valid/ready handshake.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : neuron_seq_fp16_if.master (control, memories, MAC, result)
// All control outputs are registered; mac_x/mac_c are pass-throughs of the
// memory data, and w_addr is registered as w_base + x_addr (mod 2^WAW).
// ---------------------------------------------------------------------------
module neuron_seq_fp16
    import nn_fp16_pkg::*;
#(
    parameter int N_IN = 784,
    parameter int AW   = $clog2(N_IN),
    parameter int WAW  = 17,
    parameter int RELU = 1
) (
    input logic               clk,
    input logic               rst_n,
    neuron_seq_fp16_if.master bus
);

    localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);

    nseq_state_t    state_q,   state_d;
    logic [AW-1:0]  k_q,       k_d;
    logic [WAW-1:0] wbase_q,   wbase_d;
    logic           busy_q,    busy_d;
    logic           rd_en_q,   rd_en_d;
    logic [AW-1:0]  x_addr_q,  x_addr_d;
    logic [WAW-1:0] w_addr_q,  w_addr_d;
    logic           mac_clr_q, mac_clr_d;
    logic           mac_en_q,  mac_en_d;
    fp16_t          o_q,       o_d;
    logic           o_valid_q, o_valid_d;
    fp16_t          relu_y;

    relu_fp16 u_relu (
        .a  (bus.mac_o),
        .en (RELU != 0),
        .y  (relu_y)
    );

    // Next-state and next-output decode. Outputs are computed for the
    // state being entered so that they are registered yet aligned with it.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wbase_d   = wbase_q;
        busy_d    = busy_q;
        rd_en_d   = 1'b0;
        x_addr_d  = {AW{1'b0}};
        mac_clr_d = 1'b0;
        mac_en_d  = 1'b0;
        o_d       = o_q;
        o_valid_d = o_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CLR;
                    wbase_d   = bus.w_base;
                    k_d       = {AW{1'b0}};
                    busy_d    = 1'b1;
                    mac_clr_d = 1'b1;
                    rd_en_d   = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            CLR: begin
                // Element 0 arrives next cycle; prefetch element 1.
                state_d  = RUN;
                k_d      = {AW{1'b0}};
                busy_d   = 1'b1;
                mac_en_d = 1'b1;
                rd_en_d  = 1'b1;
                x_addr_d = AW'(1);
            end
            RUN: begin
                busy_d = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = CAPT;
                end else begin
                    k_d      = k_q + AW'(1);
                    mac_en_d = 1'b1;
                    // Keep one element ahead; stop issuing after the last.
                    if ((int'(k_q) + 2) <= (N_IN - 1)) begin
                        rd_en_d  = 1'b1;
                        x_addr_d = k_q + AW'(2);
                    end else begin
                        rd_en_d  = 1'b0;
                    end
                end
            end
            CAPT: begin
                // The MAC register took its last update one edge ago.
                state_d   = DONE;
                busy_d    = 1'b1;
                o_d       = relu_y;
                o_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.o_ready) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    o_valid_d = 1'b0;
                end else begin
                    busy_d    = 1'b1;
                    o_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                o_valid_d = 1'b0;
            end
        endcase

        w_addr_d = wbase_d + WAW'(x_addr_d);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= {AW{1'b0}};
            wbase_q   <= {WAW{1'b0}};
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            x_addr_q  <= {AW{1'b0}};
            w_addr_q  <= {WAW{1'b0}};
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            o_q       <= FP16_POS_ZERO;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wbase_q   <= wbase_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            x_addr_q  <= x_addr_d;
            w_addr_q  <= w_addr_d;
            mac_clr_q <= mac_clr_d;
            mac_en_q  <= mac_en_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.x_addr  = x_addr_q;
    assign bus.w_addr  = w_addr_q;
    assign bus.mac_clr = mac_clr_q;
    assign bus.mac_en  = mac_en_q;
    assign bus.mac_x   = bus.x_data;
    assign bus.mac_c   = bus.w_data;
    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;

endmodule
